// File: rtl/readout_arbiter_if.sv
// Readout handshake bundle between trigger requesters, the arbiter and the
// command manager.
//   req_valid/req_empty      : requester -> arbiter, level request + empty-event tag
//   req_grant/req_done       : arbiter -> requester, one-cycle pulses
//   cm_readout_ready/done    : command manager -> arbiter
//   cm_initiate_readout,
//   cm_send_empty_event,
//   cm_source                : arbiter -> command manager
// The slave modport is the arbiter's view; master is the environment's view.
interface readout_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_empty;
    logic [NUM_REQ-1:0] req_grant;
    logic [NUM_REQ-1:0] req_done;
    logic               cm_readout_ready;
    logic               cm_readout_done;
    logic               cm_initiate_readout;
    logic               cm_send_empty_event;
    logic [IDX_W-1:0]   cm_source;

    modport slave (
        input  req_valid, req_empty, cm_readout_ready, cm_readout_done,
        output req_grant, req_done, cm_initiate_readout, cm_send_empty_event, cm_source
    );

    modport master (
        output req_valid, req_empty, cm_readout_ready, cm_readout_done,
        input  req_grant, req_done, cm_initiate_readout, cm_send_empty_event, cm_source
    );
endinterface

// File: rtl/readout_arbiter.sv
// Round-robin arbiter sharing the command manager's single readout path
// between NUM_REQ requesters, with a watchdog on each readout.
//   clk, reset_n        : clock, asynchronous active-low reset
//   bus (slave)         : request/grant/done and command-manager handshake
//   state               : one-hot FSM state (IDLE, ISSUE, WAIT_DONE, DONE, ERROR)
//   readout_count       : completed readouts, wrapping
//   error_timeout       : sticky, watchdog expired
//   error_spurious_done : sticky, cm_readout_done outside WAIT_DONE
module readout_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 32'd125000000
) (
    input  logic              clk,
    input  logic              reset_n,
    readout_arbiter_if.slave  bus,
    output logic [4:0]        state,
    output logic [31:0]       readout_count,
    output logic              error_timeout,
    output logic              error_spurious_done
);
    localparam int unsigned WD_W  = 32;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        ISSUE     = 5'b00010,
        WAIT_DONE = 5'b00100,
        DONE      = 5'b01000,
        ERROR     = 5'b10000
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_empty;
    logic               win_found;
    int unsigned        cand;
    logic [NUM_REQ-1:0] cand_mask;
    logic [WD_W-1:0]    wd_q;
    logic [WD_W-1:0]    wd_d;

    assign state = state_q;

    // Round-robin search starting one past the last granted requester
    always_comb begin
        win_idx   = last_grant;
        win_empty = 1'b0;
        win_found = 1'b0;
        cand      = 0;
        cand_mask = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand      = (32'(last_grant) + i) % NUM_REQ;
            cand_mask = NUM_REQ'(1) << cand;
            if (!win_found && (|(bus.req_valid & cand_mask))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
                win_empty = |(bus.req_empty & cand_mask);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state and watchdog; a done in the final watchdog cycle wins over the timeout
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cm_readout_ready && win_found) state_d = ISSUE;
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.cm_readout_done) begin
                    state_d = DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
                    state_d = ERROR;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs, loaded from the state being entered so they align with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.req_grant           <= '0;
            bus.req_done            <= '0;
            bus.cm_initiate_readout <= 1'b0;
            bus.cm_send_empty_event <= 1'b0;
            bus.cm_source           <= '0;
            last_grant              <= IDX_W'(NUM_REQ - 1);
            readout_count           <= '0;
            error_timeout           <= 1'b0;
            error_spurious_done     <= 1'b0;
        end else begin
            bus.req_grant           <= (state_d == ISSUE) ? (NUM_REQ'(1) << win_idx) : '0;
            bus.req_done            <= (state_d == DONE) ? (NUM_REQ'(1) << bus.cm_source) : '0;
            bus.cm_initiate_readout <= (state_d == ISSUE);
            bus.cm_send_empty_event <= (state_d == ISSUE) && win_empty;
            if (state_d == ISSUE) begin
                bus.cm_source <= win_idx;
                last_grant    <= win_idx;
            end
            if (state_d == DONE) readout_count <= readout_count + CNT_W'(1);
            if (state_d == ERROR) error_timeout <= 1'b1;
            if (bus.cm_readout_done &&
                ((state_q == IDLE) || (state_q == ISSUE) || (state_q == DONE)))
                error_spurious_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_readout_arbiter.sv
module tb_readout_arbiter;
    logic        clk;
    logic        reset_n;
    logic [4:0]  state;
    logic [31:0] readout_count;
    logic        error_timeout;
    logic        error_spurious_done;
    int          total;
    int          bad;

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_ISSUE = 5'b00010;
    localparam logic [4:0] S_WAIT  = 5'b00100;
    localparam logic [4:0] S_DONE  = 5'b01000;
    localparam logic [4:0] S_ERROR = 5'b10000;

    readout_arbiter_if #(.NUM_REQ(4), .IDX_W(2)) bus ();

    readout_arbiter #(.NUM_REQ(4), .IDX_W(2), .TIMEOUT_CYCLES(16)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .bus                 (bus),
        .state               (state),
        .readout_count       (readout_count),
        .error_timeout       (error_timeout),
        .error_spurious_done (error_spurious_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.req_valid       = '0;
        bus.req_empty       = '0;
        bus.cm_readout_done = 1'b0;
        reset_n             = 1'b0;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n                = 1'b0;
        bus.req_valid          = '0;
        bus.req_empty          = '0;
        bus.cm_readout_ready   = 1'b1;
        bus.cm_readout_done    = 1'b0;
        step();
        total++;
        if (state !== S_IDLE) begin
            bad++; $display("FAIL reset_state got=%b exp=%b", state, S_IDLE);
        end
        total++;
        if ({bus.req_grant, bus.req_done, bus.cm_initiate_readout, bus.cm_send_empty_event,
             bus.cm_source} !== 12'd0) begin
            bad++; $display("FAIL reset_bus got=%b exp=0", {bus.req_grant, bus.req_done,
                bus.cm_initiate_readout, bus.cm_send_empty_event, bus.cm_source});
        end
        total++;
        if ({readout_count, error_timeout, error_spurious_done} !== 34'd0) begin
            bad++; $display("FAIL reset_status got=%0h exp=0",
                {readout_count, error_timeout, error_spurious_done});
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0100;
        step();
        total++;
        if ({bus.req_grant, bus.cm_initiate_readout, bus.cm_source, state} !== {4'b0100, 1'b1, 2'd2, S_ISSUE}) begin
            bad++; $display("FAIL single_issue got=%b/%b/%0d/%b exp=0100/1/2/00010",
                bus.req_grant, bus.cm_initiate_readout, bus.cm_source, state);
        end
        total++;
        if (bus.cm_send_empty_event !== 1'b0) begin
            bad++; $display("FAIL single_empty got=%b exp=0", bus.cm_send_empty_event);
        end
        bus.req_valid = 4'b0000;
        step();
        total++;
        if ({bus.req_grant, bus.cm_initiate_readout, state} !== {4'b0000, 1'b0, S_WAIT}) begin
            bad++; $display("FAIL single_wait got=%b/%b/%b exp=0000/0/00100",
                bus.req_grant, bus.cm_initiate_readout, state);
        end
        bus.cm_readout_done = 1'b1;
        step();
        bus.cm_readout_done = 1'b0;
        total++;
        if ({bus.req_done, readout_count, state} !== {4'b0100, 32'd1, S_DONE}) begin
            bad++; $display("FAIL single_done got=%b/%0d/%b exp=0100/1/01000",
                bus.req_done, readout_count, state);
        end
        step();
        total++;
        if ({bus.req_done, state, bus.cm_source} !== {4'b0000, S_IDLE, 2'd2}) begin
            bad++; $display("FAIL single_idle got=%b/%b/%0d exp=0000/00001/2",
                bus.req_done, state, bus.cm_source);
        end
    endtask

    task automatic test_round_robin();
        int          order [6] = '{0, 1, 2, 3, 0, 3};
        logic [3:0]  exp_oh;
        apply_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) bus.req_valid = 4'b1001;
            exp_oh = 4'(1) << order[i];
            step();
            total++;
            if ({bus.req_grant, bus.cm_source} !== {exp_oh, 2'(order[i])}) begin
                bad++; $display("FAIL rr_grant%0d got=%b/%0d exp=%b/%0d", i,
                    bus.req_grant, bus.cm_source, exp_oh, order[i]);
            end
            step();
            bus.cm_readout_done = 1'b1;
            step();
            bus.cm_readout_done = 1'b0;
            total++;
            if (bus.req_done !== exp_oh) begin
                bad++; $display("FAIL rr_done%0d got=%b exp=%b", i, bus.req_done, exp_oh);
            end
            step();
        end
        bus.req_valid = 4'b0000;
        total++;
        if (readout_count !== 32'd6) begin
            bad++; $display("FAIL rr_count got=%0d exp=6", readout_count);
        end
    endtask

    task automatic test_empty_event();
        bus.req_valid = 4'b0010;
        bus.req_empty = 4'b0010;
        step();
        total++;
        if ({bus.cm_initiate_readout, bus.cm_send_empty_event, bus.cm_source} !== {1'b1, 1'b1, 2'd1}) begin
            bad++; $display("FAIL empty_issue got=%b/%b/%0d exp=1/1/1",
                bus.cm_initiate_readout, bus.cm_send_empty_event, bus.cm_source);
        end
        bus.req_valid = 4'b0000;
        step();
        total++;
        if (bus.cm_send_empty_event !== 1'b0) begin
            bad++; $display("FAIL empty_wait got=%b exp=0", bus.cm_send_empty_event);
        end
        bus.cm_readout_done = 1'b1;
        step();
        bus.cm_readout_done = 1'b0;
        step();
        bus.req_empty = 4'b0000;
        bus.req_valid = 4'b0010;
        step();
        total++;
        if ({bus.cm_initiate_readout, bus.cm_send_empty_event} !== 2'b10) begin
            bad++; $display("FAIL empty_normal got=%b/%b exp=1/0",
                bus.cm_initiate_readout, bus.cm_send_empty_event);
        end
        bus.req_valid = 4'b0000;
        step();
        bus.cm_readout_done = 1'b1;
        step();
        bus.cm_readout_done = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        int stalls;
        stalls = 0;
        bus.cm_readout_ready = 1'b0;
        bus.req_valid        = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step();
            if ((bus.req_grant !== 4'b0000) || (state !== S_IDLE)) stalls++;
        end
        total++;
        if (stalls !== 0) begin
            bad++; $display("FAIL bp_hold got=%0d exp=0 bad cycles", stalls);
        end
        bus.cm_readout_ready = 1'b1;
        step();
        total++;
        if (bus.req_grant !== 4'b0001) begin
            bad++; $display("FAIL bp_grant got=%b exp=0001", bus.req_grant);
        end
        bus.req_valid = 4'b0000;
        step();
        bus.cm_readout_done = 1'b1;
        step();
        bus.cm_readout_done = 1'b0;
        step();
    endtask

    task automatic test_watchdog_late_done();
        int not_wait;
        not_wait = 0;
        bus.req_valid = 4'b0001;
        step();
        bus.req_valid = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            step();
            if (state !== S_WAIT) not_wait++;
        end
        total++;
        if (not_wait !== 0) begin
            bad++; $display("FAIL wd_late_wait got=%0d exp=0 bad cycles", not_wait);
        end
        bus.cm_readout_done = 1'b1;
        step();
        bus.cm_readout_done = 1'b0;
        total++;
        if ({state, error_timeout} !== {S_DONE, 1'b0}) begin
            bad++; $display("FAIL wd_late_done got=%b/%b exp=01000/0", state, error_timeout);
        end
        step();
    endtask

    task automatic test_spurious_done();
        total++;
        if (error_spurious_done !== 1'b0) begin
            bad++; $display("FAIL spur_pre got=%b exp=0", error_spurious_done);
        end
        bus.cm_readout_done = 1'b1;
        step();
        bus.cm_readout_done = 1'b0;
        total++;
        if ({error_spurious_done, state} !== {1'b1, S_IDLE}) begin
            bad++; $display("FAIL spur_idle got=%b/%b exp=1/00001", error_spurious_done, state);
        end
        step();
    endtask

    task automatic test_watchdog_timeout();
        int not_wait;
        int leaks;
        not_wait = 0;
        leaks    = 0;
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            step();
            if (state !== S_WAIT) not_wait++;
        end
        total++;
        if (not_wait !== 0) begin
            bad++; $display("FAIL wd_to_wait got=%0d exp=0 bad cycles", not_wait);
        end
        step();
        total++;
        if ({state, error_timeout} !== {S_ERROR, 1'b1}) begin
            bad++; $display("FAIL wd_to_error got=%b/%b exp=10000/1", state, error_timeout);
        end
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            if ((bus.req_grant !== 4'b0000) || (bus.cm_initiate_readout !== 1'b0) ||
                (state !== S_ERROR) || (error_timeout !== 1'b1)) leaks++;
        end
        bus.req_valid = 4'b0000;
        total++;
        if (leaks !== 0) begin
            bad++; $display("FAIL wd_to_sticky got=%0d exp=0 bad cycles", leaks);
        end
    endtask

    task automatic test_reset_mid();
        int leaks;
        leaks = 0;
        apply_reset();
        total++;
        if ({error_timeout, error_spurious_done, state} !== {2'b00, S_IDLE}) begin
            bad++; $display("FAIL rst_clear got=%b/%b/%b exp=0/0/00001",
                error_timeout, error_spurious_done, state);
        end
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b0000;
        step();
        total++;
        if (state !== S_WAIT) begin
            bad++; $display("FAIL rst_pre_wait got=%b exp=00100", state);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({state, bus.req_grant, bus.req_done, bus.cm_initiate_readout, bus.cm_send_empty_event,
             bus.cm_source, readout_count} !== {S_IDLE, 44'd0}) begin
            bad++; $display("FAIL rst_async got=%b/%b/%b/%b/%b/%0d/%0d exp=00001/all 0",
                state, bus.req_grant, bus.req_done, bus.cm_initiate_readout,
                bus.cm_send_empty_event, bus.cm_source, readout_count);
        end
        step();
        reset_n = 1'b1;
        bus.cm_readout_done = 1'b1;
        step();
        bus.cm_readout_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if ((bus.req_done !== 4'b0000) || (state !== S_IDLE)) leaks++;
        end
        total++;
        if (leaks !== 0) begin
            bad++; $display("FAIL rst_no_done got=%0d exp=0 bad cycles", leaks);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_empty_event();
        test_backpressure();
        test_watchdog_late_done();
        test_spurious_done();
        test_watchdog_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/readout_arbiter.md
Name: readout_arbiter

Overview:
- Shares the command manager's single readout path between NUM_REQ trigger-processing requesters, e.g. one per trigger type or channel group.
- Accepts level requests, each tagged as a normal or an empty event.
- Picks a winner round-robin, issues a one-cycle initiate (plus empty-event flag) to the command manager, then waits for readout_done.
- Returns the done pulse to the winning requester and supervises the readout with a watchdog timeout.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- IDX_W, 2: width of the requester index; must be >= clog2(NUM_REQ).
- TIMEOUT_CYCLES, 32'd125000000: maximum WAIT_DONE duration in clk cycles (1 s at 125 MHz); 0 disables the watchdog.

Ports:
- clk  input  1  125 MHz clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester readout request, level, held until its req_grant
- req_empty  input  NUM_REQ  per-requester flag: request is an empty event
- req_grant  output  NUM_REQ  one-cycle pulse: request accepted, readout issued
- req_done  output  NUM_REQ  one-cycle pulse: granted readout finished
- cm_readout_ready  input  1  command manager idle
- cm_readout_done  input  1  command manager finished the current readout (pulse)
- cm_initiate_readout  output  1  one-cycle readout request to the command manager
- cm_send_empty_event  output  1  qualifies cm_initiate_readout as an empty event
- cm_source  output  IDX_W  index of the current or last granted requester
- state  output  5  one-hot FSM state
- readout_count  output  32  completed readouts, wraps at 2^32
- error_timeout  output  1  sticky: watchdog expired
- error_spurious_done  output  1  sticky: cm_readout_done seen outside WAIT_DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset values:
  - state = IDLE (5'b00001).
  - All outputs registered, all 0.
  - Round-robin pointer set so requester 0 has highest priority.
  - Watchdog counter = 0.
- States: bit0 IDLE, bit1 ISSUE, bit2 WAIT_DONE, bit3 DONE, bit4 ERROR.
- IDLE:
  - If cm_readout_ready and |req_valid: winner k = first set req_valid bit at or after (last_grant+1) mod NUM_REQ.
  - Latch k and req_empty[k]; go to ISSUE.
  - Otherwise stay in IDLE.
  - A request dropped before arbitration is simply not considered.
- ISSUE (exactly 1 cycle):
  - cm_initiate_readout=1, req_grant[k]=1, cm_send_empty_event=latched empty flag, cm_source=k.
  - Update last_grant=k; clear the watchdog; go to WAIT_DONE.
- WAIT_DONE:
  - cm_readout_done=1 -> DONE.
  - Otherwise the watchdog increments each cycle.
  - When TIMEOUT_CYCLES != 0 and watchdog == TIMEOUT_CYCLES-1 with no done -> ERROR.
  - Done in that same cycle takes priority over the timeout.
- DONE (exactly 1 cycle): req_done[k]=1, readout_count+1, then IDLE.
- ERROR:
  - error_timeout=1; held until reset.
  - No further grants or initiates.
  - req_valid is ignored.
- Latency:
  - Request sampled in IDLE at cycle T -> grant/initiate at T+1.
  - Done sampled at cycle D -> req_done at D+1, back in IDLE at D+2.
  - Earliest next initiate is D+3.
- cm_readout_done in IDLE, ISSUE or DONE:
  - Ignored for sequencing.
  - Sets error_spurious_done (sticky until reset).
  - Does not change state.
- cm_source holds the last granted index outside ISSUE; only cm_initiate_readout qualifies it.
- cm_send_empty_event is 0 whenever cm_initiate_readout is 0.
- The requester must deassert req_valid in the cycle after req_grant if it has no further request.
  - A still-asserted req_valid is treated as a new request after DONE.
- Asynchronous reset mid-operation:
  - Immediately returns to IDLE with all outputs 0 and the sticky errors cleared.
  - Any pending readout is abandoned, and no req_done is generated for it.

Test Plan:
- Single request: after reset, req_valid=4'b0100, req_empty=0, ready=1 at T → T+1 req_grant=4'b0100, cm_initiate_readout=1, cm_source=2; done at D → D+1 req_done=4'b0100, readout_count=1.
- Round-robin: req_valid=4'b1111 held and each readout completed → grant order 0,1,2,3,0; after a grant to 3, req_valid=4'b1001 → grant 0.
- Empty event: req_valid[1]=1, req_empty[1]=1 → cm_send_empty_event=1 only in the ISSUE cycle, together with cm_initiate_readout; req_empty=0 → it stays 0.
- Backpressure: req_valid=4'b0001 with cm_readout_ready=0 for 20 cycles → no grant, state stays IDLE; ready rises at T → grant at T+1.
- Watchdog: TIMEOUT_CYCLES=16, no done → ERROR entered 16 cycles after ISSUE, error_timeout=1, no further grants; done on cycle 16 instead → DONE, no error.
- Spurious done and reset: done pulse while in IDLE → error_spurious_done=1, state unchanged; reset_n low while in WAIT_DONE → all outputs 0 immediately, state IDLE, no req_done.
